// File: rtl/load_store_sequencer_pkg.sv
// rtl/load_store_sequencer_pkg.sv - shared types and bit-extension helpers for the load/store sequencer
package load_store_sequencer_pkg;

    typedef enum logic [1:0] {
        MM_NOP           = 2'd0,
        MM_LOAD          = 2'd1,
        MM_STORE_PRELOAD = 2'd2,
        MM_STORE         = 2'd3
    } MemoryMode_t;

    typedef logic [2:0] Funct3_t;

    localparam Funct3_t F3_B  = 3'b000;
    localparam Funct3_t F3_H  = 3'b001;
    localparam Funct3_t F3_W  = 3'b010;
    localparam Funct3_t F3_BU = 3'b100;
    localparam Funct3_t F3_HU = 3'b101;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_LD_ISSUE,
        LS_LD_CAPT,
        LS_PRE_ISSUE,
        LS_PRE_CAPT,
        LS_ST_ISSUE,
        LS_DONE,
        LS_FAULT
    } LsuState_t;

    function automatic logic [31:0] sign_extend_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] zero_extend_byte(input logic [7:0] b);
        return {24'h0, b};
    endfunction

    function automatic logic [31:0] sign_extend_half(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] zero_extend_half(input logic [15:0] h);
        return {16'h0, h};
    endfunction

    function automatic logic funct3_legal(input logic is_store, input Funct3_t f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_sequencer_formatter.sv
// rtl/load_store_sequencer_formatter.sv - byte_lane_formatter: load extraction/extension and sb/sh word merge
module byte_lane_formatter
    import load_store_sequencer_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] rs2,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_value,
    output logic [31:0] merged_store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_value = sign_extend_byte(byte_sel);
            F3_BU:   load_value = zero_extend_byte(byte_sel);
            F3_H:    load_value = sign_extend_half(half_sel);
            F3_HU:   load_value = zero_extend_half(half_sel);
            default: load_value = word;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the preloaded word passes through.
    always_comb begin
        merged_store_word = word;
        case (funct3[1:0])
            2'b00: merged_store_word[{offset, 3'b000} +: 8] = rs2[7:0];
            2'b01: begin
                if (offset[1]) begin
                    merged_store_word[31:16] = rs2[15:0];
                end else begin
                    merged_store_word[15:0] = rs2[15:0];
                end
            end
            default: merged_store_word = rs2;
        endcase
    end

endmodule

// File: rtl/load_store_sequencer.sv
// rtl/load_store_sequencer.sv - sequences memory-controller modes for one load/store, incl. sb/sh read-modify-write
module load_store_sequencer
    import load_store_sequencer_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_imm_i,
    input  logic [31:0] req_imm_s,
    input  logic [31:0] req_rs2,
    output MemoryMode_t mem_mode,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_rs1,
    output logic [31:0] mem_imm_i,
    output logic [31:0] mem_imm_s,
    output logic [31:0] mem_store_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_unaligned,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        error
);

    localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

    LsuState_t   state;
    LsuState_t   state_next;
    logic [1:0]  cnt;
    logic        r_store;
    logic [31:0] r_rs2;
    logic        accept;
    logic        mem_active;
    logic [1:0]  offset;
    logic [31:0] fmt_load;
    logic [31:0] fmt_merged;

    assign accept = (state == LS_IDLE) && req_valid && !error;
    assign offset = mem_rs1[1:0] + (r_store ? mem_imm_s[1:0] : mem_imm_i[1:0]);

    byte_lane_formatter u_formatter (
        .word              (mem_read_data),
        .rs2               (r_rs2),
        .offset            (offset),
        .funct3            (mem_funct3),
        .load_value        (fmt_load),
        .merged_store_word (fmt_merged)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LS_IDLE: begin
                if (accept) begin
                    if (!funct3_legal(req_store, req_funct3)) begin
                        state_next = LS_FAULT;
                    end else if (!req_store) begin
                        state_next = LS_LD_ISSUE;
                    end else if (req_funct3 == F3_W) begin
                        state_next = LS_ST_ISSUE;
                    end else begin
                        state_next = LS_PRE_ISSUE;
                    end
                end
            end
            LS_LD_ISSUE:  if (cnt == CNT_LAST) state_next = LS_LD_CAPT;
            LS_LD_CAPT:   state_next = LS_DONE;
            LS_PRE_ISSUE: if (cnt == CNT_LAST) state_next = LS_PRE_CAPT;
            LS_PRE_CAPT:  state_next = LS_ST_ISSUE;
            LS_ST_ISSUE:  state_next = LS_DONE;
            LS_DONE:      state_next = LS_IDLE;
            LS_FAULT:     state_next = LS_IDLE;
            default:      state_next = LS_IDLE;
        endcase
        // Unaligned flag from the controller overrides any sequencing step.
        if (mem_active && mem_unaligned) begin
            state_next = LS_FAULT;
        end
    end

    always_comb begin
        mem_mode = MM_NOP;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LS_LD_ISSUE, LS_LD_CAPT: begin
                mem_mode = MM_LOAD;
                busy     = 1'b1;
            end
            LS_PRE_ISSUE, LS_PRE_CAPT: begin
                mem_mode = MM_STORE_PRELOAD;
                busy     = 1'b1;
            end
            LS_ST_ISSUE: begin
                mem_mode = MM_STORE;
                busy     = 1'b1;
            end
            LS_DONE, LS_FAULT: done = 1'b1;
            default: ;
        endcase
        mem_active = (mem_mode != MM_NOP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 2'd0;
        end else if (((state == LS_LD_ISSUE) || (state == LS_PRE_ISSUE)) && (state_next == state)) begin
            cnt <= cnt + 2'd1;
        end else begin
            cnt <= 2'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_funct3     <= 3'd0;
            mem_rs1        <= 32'd0;
            mem_imm_i      <= 32'd0;
            mem_imm_s      <= 32'd0;
            r_store        <= 1'b0;
            r_rs2          <= 32'd0;
            mem_store_data <= 32'd0;
            load_result    <= 32'd0;
            error          <= 1'b0;
        end else begin
            if (accept) begin
                mem_funct3 <= req_funct3;
                mem_rs1    <= req_rs1;
                mem_imm_i  <= req_imm_i;
                mem_imm_s  <= req_imm_s;
                r_store    <= req_store;
                r_rs2      <= req_rs2;
                // sw drives rs2 directly; sb/sh overwrite this with the merged word in PRE_CAPT.
                if (req_store) begin
                    mem_store_data <= req_rs2;
                end
            end
            if (state == LS_LD_CAPT) begin
                load_result <= fmt_load;
            end
            if (state == LS_PRE_CAPT) begin
                mem_store_data <= fmt_merged;
            end
            if (state_next == LS_FAULT) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_sequencer.sv
// tb/tb_load_store_sequencer.sv - randomized self-checking bench for load_store_sequencer
module tb_load_store_sequencer;
    import load_store_sequencer_pkg::*;

    localparam int RL = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_rs1 = 32'd0;
    logic [31:0] req_imm_i = 32'd0;
    logic [31:0] req_imm_s = 32'd0;
    logic [31:0] req_rs2 = 32'd0;
    logic        mem_unaligned = 1'b0;
    MemoryMode_t mem_mode;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rs1, mem_imm_i, mem_imm_s, mem_store_data, mem_read_data, load_result;
    logic        busy, done, error;

    logic [31:0] rd_word = 32'd0;
    int          rd_cnt = 0;
    int          n_ld_cyc = 0;
    int          n_pre_cyc = 0;
    logic [31:0] store_log[$];
    logic [31:0] exp_last_load = 32'd0;
    int          n_checks = 0;
    int          n_errors = 0;

    load_store_sequencer #(.READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_store(req_store),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_imm_i(req_imm_i), .req_imm_s(req_imm_s),
        .req_rs2(req_rs2), .mem_mode(mem_mode), .mem_funct3(mem_funct3), .mem_rs1(mem_rs1),
        .mem_imm_i(mem_imm_i), .mem_imm_s(mem_imm_s), .mem_store_data(mem_store_data),
        .mem_read_data(mem_read_data), .mem_unaligned(mem_unaligned), .busy(busy), .done(done),
        .load_result(load_result), .error(error)
    );

    always #5 clock = ~clock;

    // Controller model: read data is valid only once a read mode has been held RL cycles.
    assign mem_read_data = (rd_cnt >= RL) ? rd_word : 32'hBAD0_BAD0;

    always @(posedge clock) begin
        if (mem_mode == MM_LOAD || mem_mode == MM_STORE_PRELOAD) rd_cnt <= rd_cnt + 1;
        else rd_cnt <= 0;
        if (mem_mode == MM_LOAD) n_ld_cyc <= n_ld_cyc + 1;
        if (mem_mode == MM_STORE_PRELOAD) n_pre_cyc <= n_pre_cyc + 1;
        if (mem_mode == MM_STORE) store_log.push_back(mem_store_data);
    end

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] sb, sh;
        int v;
        sb = w >> (8 * int'(off));
        sh = w >> (16 * int'(off[1]));
        case (f3)
            3'b000: begin v = $signed(sb[7:0]); return v; end
            3'b001: begin v = $signed(sh[15:0]); return v; end
            3'b100: return {24'h0, sb[7:0]};
            3'b101: return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] rs2, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] mask;
        int sa;
        if (f3 == 3'b000) begin
            sa = 8 * int'(off);
            mask = 32'h0000_00FF << sa;
        end else if (f3 == 3'b001) begin
            sa = 16 * int'(off[1]);
            mask = 32'h0000_FFFF << sa;
        end else begin
            return rs2;
        end
        return (w & ~mask) | ((rs2 << sa) & mask);
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = 1'b0;
        mem_unaligned = 1'b0;
        step;
        step;
        reset = 1'b0;
        exp_last_load = 32'd0;
    endtask

    task automatic run_txn(input string name, input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [31:0] rs2, input logic [31:0] word);
        logic [31:0] addr, e_res, e_data;
        int lat, e_ld, e_pre, e_st, n, ld0, pre0, st0;
        addr = rs1 + imm;
        e_ld = 0; e_pre = 0; e_st = 0; e_res = exp_last_load; e_data = 32'd0;
        if (!st) begin
            lat = 2 + RL; e_ld = RL + 1; e_res = model_load(word, f3, addr[1:0]);
        end else if (f3 == 3'b010) begin
            lat = 2; e_st = 1; e_data = rs2;
        end else begin
            lat = 3 + RL; e_pre = RL + 1; e_st = 1; e_data = model_merge(word, rs2, addr[1:0], f3);
        end
        ld0 = n_ld_cyc; pre0 = n_pre_cyc; st0 = store_log.size();
        rd_word = word;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_rs1 = rs1; req_rs2 = rs2;
        req_imm_i = st ? $urandom : imm;
        req_imm_s = st ? imm : $urandom;
        step;
        req_valid = 1'b0; req_funct3 = 3'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
        req_imm_i = $urandom; req_imm_s = $urandom;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL %s busy: got %b want 1", name, busy); end
        n_checks++; if (mem_rs1 !== rs1 || mem_funct3 !== f3) begin n_errors++; $display("FAIL %s regfields: got %h/%0d want %h/%0d", name, mem_rs1, mem_funct3, rs1, f3); end
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        n_checks++; if (n != lat) begin n_errors++; $display("FAIL %s latency: got %0d want %0d", name, n, lat); end
        n_checks++; if (load_result !== e_res) begin n_errors++; $display("FAIL %s load_result: got %h want %h", name, load_result, e_res); end
        n_checks++; if (n_ld_cyc - ld0 != e_ld) begin n_errors++; $display("FAIL %s load_cycles: got %0d want %0d", name, n_ld_cyc - ld0, e_ld); end
        n_checks++; if (n_pre_cyc - pre0 != e_pre) begin n_errors++; $display("FAIL %s preload_cycles: got %0d want %0d", name, n_pre_cyc - pre0, e_pre); end
        n_checks++; if (store_log.size() - st0 != e_st) begin n_errors++; $display("FAIL %s store_cycles: got %0d want %0d", name, store_log.size() - st0, e_st); end
        if (e_st == 1) begin
            n_checks++;
            if (store_log.size() != st0 + 1 || store_log[st0] !== e_data) begin
                n_errors++; $display("FAIL %s store_data: got %h want %h", name, mem_store_data, e_data);
            end
        end
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL %s error: got %b want 0", name, error); end
        exp_last_load = e_res;
        step;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL %s idle_after: got done=%b busy=%b want 0/0", name, done, busy); end
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++; if (mem_mode !== MM_NOP || busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL reset ctl: got mode=%0d busy=%b done=%b want 0/0/0", mem_mode, busy, done); end
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset error: got %b want 0", error); end
        n_checks++; if (load_result !== 32'd0 || mem_store_data !== 32'd0) begin n_errors++; $display("FAIL reset data: got %h/%h want 0/0", load_result, mem_store_data); end
        n_checks++; if (mem_rs1 !== 32'd0 || mem_imm_i !== 32'd0 || mem_imm_s !== 32'd0 || mem_funct3 !== 3'd0) begin n_errors++; $display("FAIL reset regfields: got %h %h %h %0d want 0", mem_rs1, mem_imm_i, mem_imm_s, mem_funct3); end
    endtask

    task automatic test_directed;
        run_txn("lw", 1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 32'hDEAD_BEEF);
        n_checks++; if (load_result !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL lw_const: got %h want deadbeef", load_result); end
        run_txn("lb", 1'b0, 3'b000, 32'h203, 32'd0, 32'd0, 32'h80FF_0000);
        n_checks++; if (load_result !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_const: got %h want ffffff80", load_result); end
        run_txn("lbu", 1'b0, 3'b100, 32'h200, 32'd3, 32'd0, 32'h80FF_0000);
        n_checks++; if (load_result !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_const: got %h want 00000080", load_result); end
        run_txn("sb", 1'b1, 3'b000, 32'h301, 32'd0, 32'h0000_00AA, 32'h1122_3344);
        n_checks++; if (store_log[store_log.size() - 1] !== 32'h1122_AA44) begin n_errors++; $display("FAIL sb_const: got %h want 1122aa44", store_log[store_log.size() - 1]); end
    endtask

    task automatic test_random;
        logic [2:0] ld_f3[5];
        logic [2:0] st_f3[3];
        logic st;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            run_txn(st ? "rand_st" : "rand_ld", st,
                    st ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)],
                    $urandom, $urandom, $urandom, $urandom);
        end
    endtask

    task automatic test_illegal_funct3;
        do_reset;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011;
        step;
        req_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL illegal_f3: got done=%b error=%b busy=%b want 1/1/0", done, error, busy); end
        step;
        n_checks++; if (done !== 1'b0 || error !== 1'b1) begin n_errors++; $display("FAIL illegal_f3_after: got done=%b error=%b want 0/1", done, error); end
    endtask

    task automatic test_unaligned_sh;
        int st0, bad;
        do_reset;
        st0 = store_log.size();
        mem_unaligned = 1'b1;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001; req_rs1 = 32'h401; req_imm_s = 32'd0;
        req_rs2 = 32'h0000_BEEF;
        step;
        req_valid = 1'b0;
        step;
        n_checks++; if (done !== 1'b1 || error !== 1'b1 || mem_mode !== MM_NOP) begin n_errors++; $display("FAIL unal_fault: got done=%b error=%b mode=%0d want 1/1/0", done, error, mem_mode); end
        mem_unaligned = 1'b0;
        req_valid = 1'b1; req_funct3 = 3'b010;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (busy !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL unal_ignore: got busy_cycles=%0d want 0", bad); end
        n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL unal_sticky: got %b want 1", error); end
        n_checks++; if (store_log.size() != st0) begin n_errors++; $display("FAIL unal_nostore: got %0d want 0", store_log.size() - st0); end
        do_reset;
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL unal_clear: got %b want 0", error); end
    endtask

    task automatic test_reset_mid;
        int st0;
        st0 = store_log.size();
        rd_word = 32'h5566_7788;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h500; req_imm_s = 32'd2;
        req_rs2 = 32'h0000_0011;
        step;
        req_valid = 1'b0;
        repeat (RL) step;
        n_checks++; if (mem_mode !== MM_STORE_PRELOAD) begin n_errors++; $display("FAIL mid_precapt: got mode=%0d want 2", mem_mode); end
        reset = 1'b1;
        step;
        n_checks++; if (mem_mode !== MM_NOP || busy !== 1'b0 || mem_store_data !== 32'd0) begin n_errors++; $display("FAIL mid_reset: got mode=%0d busy=%b data=%h want 0/0/0", mem_mode, busy, mem_store_data); end
        reset = 1'b0;
        exp_last_load = 32'd0;
        repeat (5) step;
        n_checks++; if (store_log.size() != st0) begin n_errors++; $display("FAIL mid_nostore: got %0d want 0", store_log.size() - st0); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        int st0;
        st0 = store_log.size();
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        for (int i = 0; i < 12; i++) begin
            req_rs2 = $urandom;
            req_rs1 = $urandom;
            if (i % 3 == 0) exp_q.push_back(req_rs2);
            step;
        end
        req_valid = 1'b0;
        repeat (3) step;
        n_checks++; if (store_log.size() - st0 != exp_q.size()) begin n_errors++; $display("FAIL b2b_count: got %0d want %0d", store_log.size() - st0, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (st0 + i >= store_log.size() || store_log[st0 + i] !== exp_q[i]) begin
                n_errors++; $display("FAIL b2b_data%0d: got %h want %h", i, (st0 + i < store_log.size()) ? store_log[st0 + i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_illegal_funct3;
        test_unaligned_sh;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
